// File: rtl/shift_add_multiplier_if.sv
// Start/operand/result bundle for the sequential shift-and-add multiplier.
// The controller drives the master side and the multiplier sits on the slave side.
interface shift_add_multiplier_if #(
  parameter int WORD_LENGTH = 16
);
  logic                       Shot;
  logic                       enable;
  logic [WORD_LENGTH-1:0]     multiplicand;
  logic [WORD_LENGTH-1:0]     multiplier;
  logic [2*WORD_LENGTH-1:0]   product;
  logic                       ready;
  logic                       busy;
  logic                       done;
  logic                       flag0;
  logic                       flagLast;

  modport master (
    output Shot, enable, multiplicand, multiplier,
    input  product, ready, busy, done, flag0, flagLast
  );

  modport slave (
    input  Shot, enable, multiplicand, multiplier,
    output product, ready, busy, done, flag0, flagLast
  );
endinterface

// File: rtl/shift_add_multiplier.sv
// Unsigned WORD_LENGTH x WORD_LENGTH multiplier, one partial product per enabled cycle.
// IDLE -> RUN (WORD_LENGTH steps) -> DONE (one cycle) -> IDLE.
module shift_add_multiplier #(
  parameter int WORD_LENGTH       = 16,
  parameter int NBITS_FOR_COUNTER = $clog2(WORD_LENGTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  shift_add_multiplier_if.slave bus
);
  localparam int PW = 2 * WORD_LENGTH;
  localparam logic [NBITS_FOR_COUNTER-1:0] LAST_STEP = NBITS_FOR_COUNTER'(WORD_LENGTH - 1);
  localparam logic [NBITS_FOR_COUNTER-1:0] ONE_STEP  = NBITS_FOR_COUNTER'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                       state_reg,   state_next;
  logic [NBITS_FOR_COUNTER-1:0] counter_reg, counter_next;
  logic [WORD_LENGTH-1:0]       a_reg,       a_next;
  logic [WORD_LENGTH-1:0]       b_reg,       b_next;
  logic [PW-1:0]                acc_reg,     acc_next;
  logic [PW-1:0]                product_reg, product_next;

  logic [PW-1:0] a_ext;
  logic [PW-1:0] partial [WORD_LENGTH];
  logic [PW-1:0] addend;
  logic [PW-1:0] sum;

  assign a_ext = {{WORD_LENGTH{1'b0}}, a_reg};

  // Every shifted partial product is prepared; the step counter picks one per cycle.
  generate
    for (genvar gi = 0; gi < WORD_LENGTH; gi++) begin : g_partial
      assign partial[gi] = b_reg[gi] ? (a_ext << gi) : '0;
    end
  endgenerate

  assign addend = partial[counter_reg];
  assign sum    = acc_reg + addend;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      counter_reg <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      acc_reg     <= '0;
      product_reg <= '0;
    end else begin
      state_reg   <= state_next;
      counter_reg <= counter_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
      acc_reg     <= acc_next;
      product_reg <= product_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    counter_next = counter_reg;
    a_next       = a_reg;
    b_next       = b_reg;
    acc_next     = acc_reg;
    product_next = product_reg;
    case (state_reg)
      IDLE: begin
        if (bus.Shot) begin
          a_next       = bus.multiplicand;
          b_next       = bus.multiplier;
          acc_next     = '0;
          counter_next = '0;
          state_next   = RUN;
        end
      end
      RUN: begin
        // A low enable freezes the step so no partial product is skipped.
        if (bus.enable) begin
          acc_next = sum;
          if (counter_reg == LAST_STEP) begin
            product_next = sum;
            counter_next = '0;
            state_next   = DONE;
          end else begin
            counter_next = counter_reg + ONE_STEP;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.product  = product_reg;
  assign bus.ready    = (state_reg == IDLE);
  assign bus.busy     = (state_reg == RUN);
  assign bus.done     = (state_reg == DONE);
  assign bus.flag0    = (counter_reg == '0);
  assign bus.flagLast = (counter_reg == LAST_STEP);
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier: expected products are queued at start
// and popped when done is seen; inputs change and outputs are sampled on negedge.
module tb_shift_add_multiplier;
  localparam int W = 16;

  logic clk;
  logic reset;
  int   total_cnt;
  int   pass_cnt;
  logic [2*W-1:0] exp_q[$];

  shift_add_multiplier_if #(.WORD_LENGTH(W)) mif ();

  shift_add_multiplier #(.WORD_LENGTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_ready"},    64'(mif.ready),    64'd1);
    check({tag, "_busy"},     64'(mif.busy),     64'd0);
    check({tag, "_done"},     64'(mif.done),     64'd0);
    check({tag, "_product"},  64'(mif.product),  64'd0);
    check({tag, "_flag0"},    64'(mif.flag0),    64'd1);
    check({tag, "_flagLast"}, 64'(mif.flagLast), 64'd0);
  endtask

  // Starts one operation and follows it to completion. shot_at / en_low_at are
  // cycle indices after acceptance (-1 disables); shot_done pulses Shot during DONE.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int shot_at, input int en_low_at, input int en_low_len,
                        input bit shot_done, input int exp_lat);
    int cycles;
    int busy_cnt;
    logic [2*W-1:0] exp_p;
    logic [2*W-1:0] got_p;
    exp_p = (2*W)'(a) * (2*W)'(b);
    mif.Shot         = 1'b1;
    mif.multiplicand = a;
    mif.multiplier   = b;
    exp_q.push_back(exp_p);
    @(negedge clk);
    mif.Shot = 1'b0;
    check({tag, "_accepted_busy"}, 64'(mif.busy), 64'd1);
    cycles   = 0;
    busy_cnt = 0;
    while (!mif.done && cycles < 200) begin
      if (mif.busy) busy_cnt++;
      if (cycles == exp_lat - 1) check({tag, "_flagLast"}, 64'(mif.flagLast), 64'd1);
      mif.Shot = (cycles == shot_at);
      if (cycles == shot_at) begin
        mif.multiplicand = W'($urandom);
        mif.multiplier   = W'($urandom);
      end
      mif.enable = !(en_low_at >= 0 && cycles >= en_low_at && cycles < en_low_at + en_low_len);
      @(negedge clk);
      cycles++;
    end
    mif.Shot   = 1'b0;
    mif.enable = 1'b1;
    check({tag, "_done_seen"}, 64'(mif.done), 64'd1);
    check({tag, "_latency"}, 64'(cycles), 64'(exp_lat));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
    got_p = mif.product;
    if (exp_q.size() > 0) check({tag, "_product"}, 64'(got_p), 64'(exp_q.pop_front()));
    else check({tag, "_scoreboard_empty"}, 64'(exp_q.size()), 64'd1);
    check({tag, "_flag0_wrapped"}, 64'(mif.flag0), 64'd1);
    if (shot_done) begin
      mif.Shot         = 1'b1;
      mif.multiplicand = W'($urandom);
      mif.multiplier   = W'($urandom);
    end
    @(negedge clk);
    mif.Shot = 1'b0;
    check({tag, "_done_one_cycle"}, 64'(mif.done), 64'd0);
    check({tag, "_ready_after"}, 64'(mif.ready), 64'd1);
    check({tag, "_not_restarted"}, 64'(mif.busy), 64'd0);
    @(negedge clk);
    check({tag, "_product_held"}, 64'(mif.product), 64'(exp_p));
    $display("op %s: A=%0h B=%0h product=%0h latency=%0d", tag, a, b, mif.product, cycles);
  endtask

  initial begin
    int done_pulses;
    total_cnt        = 0;
    pass_cnt         = 0;
    reset            = 1'b1;
    mif.Shot         = 1'b0;
    mif.enable       = 1'b1;
    mif.multiplicand = '0;
    mif.multiplier   = '0;
    #1;
    check_idle_reset("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_op("3x5",       16'd3,      16'd5,      -1, -1, 0, 1'b0, W);
    run_op("ffffsq",    16'hFFFF,   16'hFFFF,   -1, -1, 0, 1'b0, W);
    run_op("zeroA",     16'd0,      16'h1234,   -1, -1, 0, 1'b0, W);
    run_op("shot_ign",  16'h0021,   16'h0013,    4, -1, 0, 1'b1, W);
    run_op("en_stall",  16'h1357,   16'h2468,   -1,  5, 5, 1'b0, W + 5);
    for (int i = 0; i < 3; i++)
      run_op("random", W'($urandom), W'($urandom), -1, -1, 0, 1'b0, W);

    // Abort mid-operation: start, run 8 steps, then reset asynchronously.
    mif.Shot         = 1'b1;
    mif.multiplicand = 16'h0055;
    mif.multiplier   = 16'h0066;
    @(negedge clk);
    mif.Shot = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_counter_not0", 64'(mif.flag0), 64'd0);
    #2;
    reset = 1'b1;
    #1;
    check_idle_reset("abort");
    @(negedge clk);
    reset = 1'b0;
    done_pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mif.done) done_pulses++;
    end
    check("abort_no_done", 64'(done_pulses), 64'd0);
    check("abort_product_zero", 64'(mif.product), 64'd0);

    run_op("7x9", 16'd7, 16'd9, -1, -1, 0, 1'b0, W);
    check("final_product_63", 64'(mif.product), 64'd63);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/shift_add_multiplier.md
SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 Parameter WORD_LENGTH, default 16, is the operand width in bits; legal range 2..32.
REQ-002 Parameter NBITS_FOR_COUNTER, default CeilLog2(WORD_LENGTH), is the step-counter width.
REQ-003 Port clk, input, 1, is the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, is the asynchronous active-high reset.
REQ-005 Port Shot, input, 1, is a one-cycle start pulse from the controller.
REQ-006 Port enable, input, 1, gates step advance in RUN.
REQ-007 Port multiplicand, input, WORD_LENGTH, is unsigned operand A, sampled on start acceptance only.
REQ-008 Port multiplier, input, WORD_LENGTH, is unsigned operand B, sampled on start acceptance only.
REQ-009 Port product, output, 2*WORD_LENGTH, is the registered unsigned result A*B.
REQ-010 Port ready, output, 1, is high only in IDLE.
REQ-011 Port busy, output, 1, is high only in RUN.
REQ-012 Port done, output, 1, is high for exactly one cycle, in DONE.
REQ-013 Port flag0, output, 1, is high when step counter == 0.
REQ-014 Port flagLast, output, 1, is high when step counter == WORD_LENGTH-1.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN, DONE; any illegal encoding SHALL return to IDLE on the next edge.
REQ-016 In IDLE, Shot=1 at an edge SHALL capture A and B, clear the accumulator and counter, and go to RUN.
REQ-017 In IDLE, Shot=0 SHALL hold state; product SHALL keep its last value.
REQ-018 In RUN with enable=1, each edge SHALL add A<<counter to the accumulator when B[counter]=1, then increment counter.
REQ-019 In RUN with enable=0, the counter, accumulator and state SHALL hold with no step lost.
REQ-020 In RUN with enable=1 and counter==WORD_LENGTH-1, the edge SHALL perform the last step, load product with the final sum, wrap counter to 0, and go to DONE.
REQ-021 In DONE, done=1 for one cycle; the next edge SHALL go to IDLE unconditionally.
REQ-022 Shot SHALL be ignored in RUN and DONE; operands captured at acceptance SHALL not change mid-operation.
REQ-023 Latency with enable held high: Shot accepted at edge E0 -> product valid and done=1 after edge E(WORD_LENGTH); ready again after edge E(WORD_LENGTH+1).
REQ-024 Arithmetic SHALL be unsigned, with the accumulator 2*WORD_LENGTH bits wide; (2^W-1)^2 SHALL fit without overflow.
REQ-025 Zero operands SHALL still take the full WORD_LENGTH steps.
REQ-026 product SHALL update only on the REQ-020 edge and hold through IDLE until the next completion.
REQ-027 flag0 and flagLast SHALL be combinational decodes of the counter, valid in every state.

Reset
REQ-028 Asserting reset SHALL immediately force state=IDLE, counter=0, accumulator=0, product=0, done=0, busy=0, ready=1, flag0=1, flagLast=0.
REQ-029 Reset mid-RUN SHALL abort the operation, with no done pulse and product=0.
REQ-030 The first Shot after reset release SHALL be accepted normally.

Verification
REQ-031 W=16, A=3, B=5, Shot one cycle, enable=1 -> done high exactly 16 edges after acceptance, product=15, then ready=1.
REQ-032 W=16, A=B=0xFFFF -> product=0xFFFE0001 and done one cycle wide.
REQ-033 A=0, B=0x1234 -> product=0 after the full 16 steps, with busy high for 16 cycles.
REQ-034 Shot pulses at step 4, and in the DONE cycle, with different operands -> ignored; product equals the first operands' product.
REQ-035 enable low for 5 cycles during RUN -> done delayed by exactly 5 cycles, result unchanged.
REQ-036 reset asserted at step 8 -> immediate IDLE, product=0, no done pulse; a new Shot with A=7, B=9 -> product=63.
